// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory port.
// slave: arbiter view. master: requester/memory view (testbench side).
interface mem_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  logic [ADDR_W-1:0] imem_addr;
  logic [MASK_W-1:0] imem_rmask;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_resp;

  logic [ADDR_W-1:0] dmem_addr;
  logic [MASK_W-1:0] dmem_rmask;
  logic [MASK_W-1:0] dmem_wmask;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_resp;

  logic [ADDR_W-1:0] mem_addr;
  logic [MASK_W-1:0] mem_rmask;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_resp;

  modport slave (
    input  imem_addr, imem_rmask,
    output imem_rdata, imem_resp,
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp,
    output mem_addr, mem_rmask, mem_wmask, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output imem_addr, imem_rmask,
    input  imem_rdata, imem_resp,
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp,
    input  mem_addr, mem_rmask, mem_wmask, mem_wdata,
    output mem_rdata, mem_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter onto a single registered memory port.
// Optional macro ARB_RR_EN: round-robin on simultaneous requests
// (default: fixed priority, data over fetch).
module mem_arbiter (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, IDRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  state_t   state_q, state_d;
  mem_req_t req_q, req_d;
  mem_req_t fetch_req, data_req;
  logic     armed_q;
  logic     i_req, d_req;
  logic     sample, elig_i, elig_d;
  logic     pick_i, pick_d;
  logic     data_wins;

  assign i_req = |bus.imem_rmask;
  assign d_req = (|bus.dmem_rmask) | (|bus.dmem_wmask);

  // Payloads as they would be latched onto the memory port; a write masks off the read.
  always_comb begin
    fetch_req       = '0;
    fetch_req.addr  = bus.imem_addr;
    fetch_req.rmask = bus.imem_rmask;
    data_req        = '0;
    data_req.addr   = bus.dmem_addr;
    if (|bus.dmem_wmask) begin
      data_req.wmask = bus.dmem_wmask;
      data_req.wdata = bus.dmem_wdata;
    end else begin
      data_req.rmask = bus.dmem_rmask;
    end
  end

`ifdef ARB_RR_EN
  logic prio_data_q;

  // Round-robin pointer: data wins the first conflict out of reset, then the side not last granted wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_data_q <= 1'b1;
    end else if (pick_d) begin
      prio_data_q <= 1'b0;
    end else if (pick_i) begin
      prio_data_q <= 1'b1;
    end
  end

  assign data_wins = prio_data_q;
`else
  assign data_wins = 1'b1;
`endif

  // Blocks grants on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, eligibility and grant; the served requester is excluded on its resp cycle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    sample  = 1'b0;
    elig_i  = 1'b0;
    elig_d  = 1'b0;
    pick_i  = 1'b0;
    pick_d  = 1'b0;

    case (state_q)
      IDLE: begin
        sample = armed_q;
        elig_i = i_req;
        elig_d = d_req;
      end
      IBUSY: begin
        if (bus.mem_resp) begin
          sample = 1'b1;
          elig_d = d_req;
        end else if (!i_req) begin
          state_d = IDRAIN;
        end
      end
      DBUSY: begin
        if (bus.mem_resp) begin
          sample = 1'b1;
          elig_i = i_req;
        end
      end
      IDRAIN: begin
        if (bus.mem_resp) begin
          sample = 1'b1;
          elig_i = i_req;
          elig_d = d_req;
        end
      end
      default: state_d = IDLE;
    endcase

    pick_d = sample && elig_d && (!elig_i || data_wins);
    pick_i = sample && elig_i && !pick_d;

    if (pick_d) begin
      state_d = DBUSY;
      req_d   = data_req;
    end else if (pick_i) begin
      state_d = IBUSY;
      req_d   = fetch_req;
    end else if (sample && state_q != IDLE) begin
      state_d     = IDLE;
      req_d.rmask = '0;
      req_d.wmask = '0;
    end
  end

  // Memory port register; changes only on a grant or a completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q <= req_d;
    end
  end

  assign bus.mem_addr   = req_q.addr;
  assign bus.mem_rmask  = req_q.rmask;
  assign bus.mem_wmask  = req_q.wmask;
  assign bus.mem_wdata  = req_q.wdata;

  assign bus.imem_resp  = bus.mem_resp && (state_q == IBUSY);
  assign bus.dmem_resp  = bus.mem_resp && (state_q == DBUSY);
  assign bus.imem_rdata = bus.mem_rdata;
  assign bus.dmem_rdata = bus.mem_rdata;

  // A data requester must hold its mask until its resp.
  dmem_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == DBUSY) |-> d_req);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (default fixed-priority build).
module tb_mem_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    rst_n           = 1'b0;
    bus.imem_addr   = '0;
    bus.imem_rmask  = '0;
    bus.dmem_addr   = '0;
    bus.dmem_rmask  = '0;
    bus.dmem_wmask  = '0;
    bus.dmem_wdata  = '0;
    bus.mem_rdata   = '0;
    bus.mem_resp    = 1'b0;

    // Reset values
    #2;
    check("rst_addr",  bus.mem_addr, 32'h0);
    check("rst_rmask", 32'(bus.mem_rmask), 32'h0);
    check("rst_wmask", 32'(bus.mem_wmask), 32'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_iresp", 32'(bus.imem_resp), 32'h0);
    check("rst_dresp", 32'(bus.dmem_resp), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();

    // Lone fetch
    bus.imem_addr  = 32'h6000_0000;
    bus.imem_rmask = 4'hF;
    step();
    check("f1_addr",  bus.mem_addr, 32'h6000_0000);
    check("f1_rmask", 32'(bus.mem_rmask), 32'hF);
    check("f1_wmask", 32'(bus.mem_wmask), 32'h0);
    check("f1_iresp_wait", 32'(bus.imem_resp), 32'h0);
    step();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h0000_0013;
    #1;
    check("f1_iresp",  32'(bus.imem_resp), 32'h1);
    check("f1_irdata", bus.imem_rdata, 32'h0000_0013);
    check("f1_dresp",  32'(bus.dmem_resp), 32'h0);
    step();
    bus.mem_resp   = 1'b0;
    bus.imem_rmask = 4'h0;
    check("f1_clr_rmask", 32'(bus.mem_rmask), 32'h0);

    // Simultaneous fetch and data write: data first, fetch back-to-back
    step();
    bus.imem_addr  = 32'h6000_0004;
    bus.imem_rmask = 4'hF;
    bus.dmem_addr  = 32'h8000_0000;
    bus.dmem_wmask = 4'hF;
    bus.dmem_wdata = 32'hDEAD_BEEF;
    step();
    check("c_d_addr",  bus.mem_addr, 32'h8000_0000);
    check("c_d_wmask", 32'(bus.mem_wmask), 32'hF);
    check("c_d_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("c_d_rmask", 32'(bus.mem_rmask), 32'h0);
    step();
    bus.mem_resp = 1'b1;
    #1;
    check("c_dresp", 32'(bus.dmem_resp), 32'h1);
    check("c_iresp_no", 32'(bus.imem_resp), 32'h0);
    step();
    bus.mem_resp   = 1'b0;
    bus.dmem_wmask = 4'h0;
    check("c_i_addr",  bus.mem_addr, 32'h6000_0004);
    check("c_i_rmask", 32'(bus.mem_rmask), 32'hF);
    check("c_i_wmask", 32'(bus.mem_wmask), 32'h0);
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    #1;
    check("c_iresp", 32'(bus.imem_resp), 32'h1);
    step();
    bus.mem_resp   = 1'b0;
    bus.imem_rmask = 4'h0;
    check("c_clr_rmask", 32'(bus.mem_rmask), 32'h0);

    // Fetch cancel, drain, then fresh fetch
    step();
    bus.imem_addr  = 32'h6000_0010;
    bus.imem_rmask = 4'hF;
    step();
    check("x_addr", bus.mem_addr, 32'h6000_0010);
    bus.imem_rmask = 4'h0;
    step();
    check("x_hold_addr",  bus.mem_addr, 32'h6000_0010);
    check("x_hold_rmask", 32'(bus.mem_rmask), 32'hF);
    step();
    bus.imem_addr  = 32'h6000_0100;
    bus.imem_rmask = 4'hF;
    #1;
    check("x_hold_addr2", bus.mem_addr, 32'h6000_0010);
    step();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h0000_0BAD;
    #1;
    check("x_iresp_supp", 32'(bus.imem_resp), 32'h0);
    check("x_dresp_no",   32'(bus.dmem_resp), 32'h0);
    step();
    bus.mem_resp = 1'b0;
    check("x_new_addr",  bus.mem_addr, 32'h6000_0100);
    check("x_new_rmask", 32'(bus.mem_rmask), 32'hF);
    step();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h0000_0093;
    #1;
    check("x_new_iresp", 32'(bus.imem_resp), 32'h1);
    step();
    bus.mem_resp   = 1'b0;
    bus.imem_rmask = 4'h0;
    check("x_clr_rmask", 32'(bus.mem_rmask), 32'h0);

    // Mask dropped on the resp cycle still completes
    step();
    bus.imem_addr  = 32'h6000_0020;
    bus.imem_rmask = 4'hF;
    step();
    check("r_addr", bus.mem_addr, 32'h6000_0020);
    bus.imem_rmask = 4'h0;
    bus.mem_resp   = 1'b1;
    bus.mem_rdata  = 32'h0000_0033;
    #1;
    check("r_iresp", 32'(bus.imem_resp), 32'h1);
    step();
    bus.mem_resp = 1'b0;
    check("r_clr_rmask", 32'(bus.mem_rmask), 32'h0);

    // Data read
    step();
    bus.dmem_addr  = 32'h8000_0002;
    bus.dmem_rmask = 4'h3;
    step();
    check("d_addr",  bus.mem_addr, 32'h8000_0002);
    check("d_rmask", 32'(bus.mem_rmask), 32'h3);
    check("d_wmask", 32'(bus.mem_wmask), 32'h0);
    check("d_iresp0", 32'(bus.imem_resp), 32'h0);
    check("d_dresp0", 32'(bus.dmem_resp), 32'h0);
    step();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h1122_3344;
    #1;
    check("d_dresp",  32'(bus.dmem_resp), 32'h1);
    check("d_drdata", bus.dmem_rdata, 32'h1122_3344);
    check("d_iresp1", 32'(bus.imem_resp), 32'h0);
    step();
    bus.mem_resp   = 1'b0;
    bus.dmem_rmask = 4'h0;
    check("d_clr_rmask", 32'(bus.mem_rmask), 32'h0);
    check("d_dresp_off", 32'(bus.dmem_resp), 32'h0);

    // Reset in DBUSY, fetch pending across reset
    step();
    bus.dmem_addr  = 32'h8000_0010;
    bus.dmem_wmask = 4'hF;
    bus.dmem_wdata = 32'hCAFE_F00D;
    bus.imem_addr  = 32'h6000_0040;
    bus.imem_rmask = 4'hF;
    step();
    check("rd_wmask", 32'(bus.mem_wmask), 32'hF);
    check("rd_addr",  bus.mem_addr, 32'h8000_0010);
    rst_n        = 1'b0;
    bus.mem_resp = 1'b1;
    #1;
    check("rd_rst_addr",  bus.mem_addr, 32'h0);
    check("rd_rst_wmask", 32'(bus.mem_wmask), 32'h0);
    check("rd_rst_wdata", bus.mem_wdata, 32'h0);
    check("rd_rst_dresp", 32'(bus.dmem_resp), 32'h0);
    bus.dmem_wmask = 4'h0;
    step();
    bus.mem_resp = 1'b0;
    rst_n        = 1'b1;
    step();
    check("rd_nogrant", 32'(bus.mem_rmask), 32'h0);
    step();
    check("rd_f_addr",  bus.mem_addr, 32'h6000_0040);
    check("rd_f_rmask", 32'(bus.mem_rmask), 32'hF);
    step();
    bus.mem_resp  = 1'b1;
    bus.mem_rdata = 32'h0000_0073;
    #1;
    check("rd_f_iresp", 32'(bus.imem_resp), 32'h1);
    step();
    bus.mem_resp   = 1'b0;
    bus.imem_rmask = 4'h0;
    check("rd_clr_rmask", 32'(bus.mem_rmask), 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
